instr_fetch_unit: RTL

- Reads the current PC from the program counter register and issues a single-outstanding fetch to instruction memory over a req/gnt/rvalid interface.
- Presents the fetched instruction and its PC to decode with a valid/ready handshake.
- Drives the PC register's write enable, advancing only when a fetch is accepted or a redirect occurs.
- Sits between the PC register and the IF/ID boundary.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_out_reg.sv | 48 ++++
 rtl/instr_fetch_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// The state encoding is shared so the debug state port can be decoded outside the block.
package fetch_pkg;

    localparam int          DEF_PC_WIDTH    = 32;
    localparam int          DEF_INSTR_WIDTH = 32;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_HOLD  = 3'd3,
        FS_DRAIN = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// IF/ID output register: it holds the instruction while decode stalls and
// collapses to a NOP bubble on consume, flush or soft reset.
module fetch_out_reg #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_load,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [PC_WIDTH-1:0]    i_pc,
    input  logic                   i_clear,
    input  logic                   i_clear_all,
    output logic                   o_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [PC_WIDTH-1:0]    o_pc
);

    logic                   r_valid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_pc;

    // Soft reset wipes the PC too; a consume or flush only drops the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else if (i_clear_all) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch between the PC register and IF/ID.
// Handshakes: imem req/addr stay stable until gnt; if_valid_o holds its data until id_ready_i.
module instr_fetch_unit #(
    parameter int                     PC_WIDTH    = fetch_pkg::DEF_PC_WIDTH,
    parameter int                     INSTR_WIDTH = fetch_pkg::DEF_INSTR_WIDTH,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = fetch_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_en_i,
    input  logic                   soft_reset_i,
    input  logic                   flush_i,
    input  logic [PC_WIDTH-1:0]    pc_i,
    output logic                   pc_write_en_o,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   if_valid_o,
    output logic [INSTR_WIDTH-1:0] if_instr_o,
    output logic [PC_WIDTH-1:0]    if_pc_o,
    input  logic                   id_ready_i,
    output logic [2:0]             dbg_state_o
);

    import fetch_pkg::*;

    fetch_state_e        r_state;
    logic                r_req;
    logic [PC_WIDTH-1:0] r_addr;
    logic                r_drop;
    logic                r_drop_to_idle;

    logic w_accept;
    logic w_pc_we;
    logic w_out_clear;

    assign w_accept = (r_state == FS_WAIT) && imem_rvalid_i && !flush_i && !soft_reset_i;

    // The PC register advances on the accepted response and loads the redirect on flush.
    assign w_pc_we       = w_accept || (flush_i && !soft_reset_i);
    assign pc_write_en_o = rst_n && w_pc_we;

    assign w_out_clear = (r_state == FS_HOLD) && (flush_i || id_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= FS_IDLE;
            r_req          <= 1'b0;
            r_addr         <= '0;
            r_drop         <= 1'b0;
            r_drop_to_idle <= 1'b0;
        end else begin
            unique case (r_state)
                FS_IDLE: begin
                    if (!soft_reset_i && fetch_en_i) begin
                        r_state <= FS_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= pc_i;
                    end
                end

                // An ungranted request cannot be withdrawn: remember the kill and
                // keep requesting the same address until the memory takes it.
                FS_REQ: begin
                    if (soft_reset_i) begin
                        r_drop_to_idle <= 1'b1;
                    end
                    if (imem_gnt_i) begin
                        r_req <= 1'b0;
                        if (r_drop || flush_i || soft_reset_i) begin
                            r_state <= FS_DRAIN;
                        end else begin
                            r_state <= FS_WAIT;
                        end
                    end else if (flush_i || soft_reset_i) begin
                        r_drop <= 1'b1;
                    end
                end

                FS_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (soft_reset_i) begin
                            r_state <= FS_IDLE;
                        end else if (flush_i) begin
                            r_state <= FS_REQ;
                            r_req   <= 1'b1;
                            r_addr  <= pc_i;
                        end else begin
                            r_state <= FS_HOLD;
                        end
                    end else if (soft_reset_i || flush_i) begin
                        r_state <= FS_DRAIN;
                        if (soft_reset_i) begin
                            r_drop_to_idle <= 1'b1;
                        end
                    end
                end

                FS_HOLD: begin
                    if (soft_reset_i) begin
                        r_state <= FS_IDLE;
                    end else if (flush_i || id_ready_i) begin
                        r_state <= FS_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= pc_i;
                    end
                end

                FS_DRAIN: begin
                    if (soft_reset_i) begin
                        r_drop_to_idle <= 1'b1;
                    end
                    if (imem_rvalid_i) begin
                        r_drop         <= 1'b0;
                        r_drop_to_idle <= 1'b0;
                        if (r_drop_to_idle || soft_reset_i) begin
                            r_state <= FS_IDLE;
                        end else begin
                            r_state <= FS_REQ;
                            r_req   <= 1'b1;
                            r_addr  <= pc_i;
                        end
                    end
                end

                default: begin
                    r_state        <= FS_IDLE;
                    r_req          <= 1'b0;
                    r_drop         <= 1'b0;
                    r_drop_to_idle <= 1'b0;
                end
            endcase
        end
    end

    fetch_out_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .NOP_INSTR   (NOP_INSTR)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_accept),
        .i_instr     (imem_rdata_i),
        .i_pc        (r_addr),
        .i_clear     (w_out_clear),
        .i_clear_all (soft_reset_i),
        .o_valid     (if_valid_o),
        .o_instr     (if_instr_o),
        .o_pc        (if_pc_o)
    );

    assign imem_req_o  = r_req;
    assign imem_addr_o = r_addr;
    assign dbg_state_o = r_state;

endmodule
